perceptron: RTL and testbench

- Single behavioural neuron (real-valued) for the ML simulation library.
- Forward path is combinational: weighted sum of `input_units` inputs plus bias, then a selectable activation.
- Backward path: takes the downstream layer's weights and error gradients, produces this neuron's error gradient, and applies SGD to its weights and bias on each clock while training.
- Building block for layers; used standalone in logic-gate training benches.

---
 rtl/perceptron.sv | 113 +++++++++++
 tb/tb_perceptron.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron.sv
// Single real-valued neuron: combinational forward/backward path,
// SGD-trained weight and bias registers.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   values[input_units]       input activations x[i]
//   activation                activation select (Sigmoid/ReLU/Tanh/Linear)
//   training                  1 = apply one SGD step per posedge
//   learning_rate             SGD step size
//   next_layer_weights[k]     weight from this neuron into downstream k
//   error_gradient_next_layer downstream dC/d(out) contributions
//   prediction                activated output a = f(z)
//   error_gradient            delta = dC/dz of this neuron
//   current_weights           live weight registers

package common;
  typedef enum logic [1:0] {
    Sigmoid,
    ReLU,
    Tanh,
    Linear
  } act_func;
endpackage

module perceptron
  import common::*;
#(
  parameter int input_units  = 2,
  parameter int output_units = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  real     values [input_units],
  input  act_func activation,
  input  logic    training,
  input  real     learning_rate,
  input  real     next_layer_weights [output_units],
  input  real     error_gradient_next_layer [output_units],
  output real     prediction,
  output real     error_gradient,
  output real     current_weights [input_units]
);

  real w [input_units];
  real b;

  real z;
  real g;
  real a;
  real d;

  always_comb begin
    z = b;
    for (int i = 0; i < input_units; i++)
      z = z + w[i] * values[i];
  end

  always_comb begin
    g = 0.0;
    for (int k = 0; k < output_units; k++)
      g = g + next_layer_weights[k]
            * error_gradient_next_layer[k];
  end

  // Derivatives for Sigmoid/Tanh are taken from the activated
  // output a; ReLU's derivative is 0 at exactly z = 0.
  always_comb begin
    a = 0.0;
    d = 0.0;
    unique case (activation)
      Sigmoid: begin
        a = 1.0 / (1.0 + $exp(-z));
        d = a * (1.0 - a);
      end
      ReLU: begin
        a = (z > 0.0) ? z : 0.0;
        d = (z > 0.0) ? 1.0 : 0.0;
      end
      Tanh: begin
        a = $tanh(z);
        d = 1.0 - a * a;
      end
      Linear: begin
        a = z;
        d = 1.0;
      end
    endcase
  end

  assign prediction     = a;
  assign error_gradient = g * d;

  always_comb begin
    for (int i = 0; i < input_units; i++)
      current_weights[i] = w[i];
  end

  // All updates use the pre-edge error gradient, so the
  // feedback loop through prediction breaks at these registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < input_units; i++)
        w[i] <= 0.0;
      b <= 0.0;
    end else if (training) begin
      for (int i = 0; i < input_units; i++)
        w[i] <= w[i]
              - learning_rate * error_gradient * values[i];
      b <= b - learning_rate * error_gradient;
    end
  end

endmodule

// File: tb/tb_perceptron.sv
// Scoreboard bench for perceptron: stimulus queues expectations,
// a negedge monitor pops and compares them against the outputs.
`timescale 1ns/1ps

module tb_perceptron;
  import common::*;

  logic    clk;
  logic    rst;
  real     values [2];
  act_func activation;
  logic    training;
  real     learning_rate;
  real     nlw [1];
  real     egn [1];
  real     prediction;
  real     error_gradient;
  real     current_weights [2];

  int total;
  int bad;

  string qn [$];
  int    qs [$];
  real   qe [$];

  perceptron #(
    .input_units (2),
    .output_units(1)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .values                   (values),
    .activation               (activation),
    .training                 (training),
    .learning_rate            (learning_rate),
    .next_layer_weights       (nlw),
    .error_gradient_next_layer(egn),
    .prediction               (prediction),
    .error_gradient           (error_gradient),
    .current_weights          (current_weights)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // sel: 0 prediction, 1 error_gradient, 2 w0, 3 w1,
  //      4 prediction below 0.5, 5 prediction above 0.5
  task automatic push(input string n, input int s, input real e);
    qn.push_back(n);
    qs.push_back(s);
    qe.push_back(e);
  endtask

  function automatic real sigm(input real x);
    return 1.0 / (1.0 + $exp(-x));
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    forever begin
      @(negedge clk);
      while (qs.size() > 0) begin
        string n;
        int    s;
        real   e;
        real   got;
        logic  ok;
        n = qn.pop_front();
        s = qs.pop_front();
        e = qe.pop_front();
        case (s)
          0:       got = prediction;
          1:       got = error_gradient;
          2:       got = current_weights[0];
          3:       got = current_weights[1];
          default: got = prediction;
        endcase
        if (s == 4)      ok = (got < 0.5);
        else if (s == 5) ok = (got > 0.5);
        else begin
          real df;
          df = got - e;
          if (df < 0.0) df = -df;
          ok = (df < 1e-6);
        end
        total++;
        if (!ok) begin
          bad++;
          if (s == 4)
            $display("FAIL %s: got=%f required=<0.5", n, got);
          else if (s == 5)
            $display("FAIL %s: got=%f required=>0.5", n, got);
          else
            $display("FAIL %s: got=%f required=%f", n, got, e);
        end
      end
    end
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    training = 1'b0;
    edge1();
    rst = 1'b0;
  endtask

  task automatic set_bce(input real y);
    real a;
    real eps;
    eps = 1e-9;
    a   = prediction;
    egn[0] = -(y / (a + eps) - (1.0 - y) / (1.0 - a + eps));
  endtask

  initial begin
    real px [4][2];
    real py [4];
    px[0][0] = 0.0; px[0][1] = 0.0; py[0] = 0.0;
    px[1][0] = 0.0; px[1][1] = 1.0; py[1] = 0.0;
    px[2][0] = 1.0; px[2][1] = 0.0; py[2] = 0.0;
    px[3][0] = 1.0; px[3][1] = 1.0; py[3] = 1.0;

    rst           = 1'b1;
    training      = 1'b0;
    activation    = Sigmoid;
    learning_rate = 0.0;
    values[0]     = 0.0;
    values[1]     = 0.0;
    nlw[0]        = 0.0;
    egn[0]        = 0.0;

    repeat (3) @(posedge clk);
    #1;
    push("rst_w0", 2, 0.0);
    push("rst_w1", 3, 0.0);
    push("rst_pred", 0, 0.5);
    edge1();

    rst           = 1'b0;
    values[0]     = 1.0;
    values[1]     = 1.0;
    nlw[0]        = 1.0;
    egn[0]        = -2.0;
    learning_rate = 1.0;
    training      = 1'b1;
    push("sig_err", 1, -0.5);
    push("sig_pred0", 0, 0.5);
    edge1();
    training = 1'b0;
    push("sig_w0", 2, 0.5);
    push("sig_w1", 3, 0.5);
    push("sig_pred1", 0, 0.8175744762);
    edge1();

    for (int c = 0; c < 10; c++) begin
      values[0] = 0.3 * c;
      values[1] = 1.0 - 0.1 * c;
      egn[0]    = 1.0 * c;
      push("hold_pred", 0,
           sigm(0.5 + 0.5 * values[0] + 0.5 * values[1]));
      edge1();
    end
    values[0] = 0.0;
    values[1] = 0.0;
    push("hold_w0", 2, 0.5);
    push("hold_w1", 3, 0.5);
    push("hold_pred00", 0, 0.6224593312);
    edge1();

    do_reset();
    activation    = Linear;
    values[0]     = 2.0;
    values[1]     = 3.0;
    nlw[0]        = 1.0;
    egn[0]        = 1.0;
    learning_rate = 0.1;
    training      = 1'b1;
    push("lin_err", 1, 1.0);
    push("lin_pred0", 0, 0.0);
    edge1();
    training = 1'b0;
    push("lin_w0", 2, -0.2);
    push("lin_w1", 3, -0.3);
    push("lin_pred1", 0, -1.4);
    edge1();

    do_reset();
    activation    = ReLU;
    values[0]     = 1.0;
    values[1]     = 1.0;
    egn[0]        = 3.0;
    learning_rate = 1.0;
    training      = 1'b1;
    push("relu_err", 1, 0.0);
    push("relu_pred", 0, 0.0);
    edge1();
    training = 1'b0;
    push("relu_w0", 2, 0.0);
    push("relu_w1", 3, 0.0);
    edge1();

    do_reset();
    activation    = Tanh;
    values[0]     = 1.0;
    values[1]     = 0.0;
    egn[0]        = -2.0;
    learning_rate = 0.5;
    training      = 1'b1;
    push("tanh_err", 1, -2.0);
    push("tanh_pred0", 0, 0.0);
    edge1();
    training = 1'b0;
    push("tanh_w0", 2, 1.0);
    push("tanh_w1", 3, 0.0);
    push("tanh_pred1", 0, 0.9640275801);
    edge1();

    do_reset();
    activation    = Sigmoid;
    learning_rate = 1.0;
    nlw[0]        = 1.0;
    training      = 1'b1;
    for (int ep = 0; ep < 100; ep++) begin
      for (int p = 0; p < 4; p++) begin
        values[0] = px[p][0];
        values[1] = px[p][1];
        repeat (2) begin
          #1;
          set_bce(py[p]);
          edge1();
        end
      end
    end
    training = 1'b0;
    for (int p = 0; p < 4; p++) begin
      values[0] = px[p][0];
      values[1] = px[p][1];
      push($sformatf("and_p%0d", p), (p == 3) ? 5 : 4, 0.5);
      edge1();
    end

    values[0] = 1.0;
    values[1] = 1.0;
    training  = 1'b1;
    repeat (3) begin
      #1;
      set_bce(0.0);
      edge1();
    end
    rst = 1'b1;
    edge1();
    push("mid_rst_w0", 2, 0.0);
    push("mid_rst_w1", 3, 0.0);
    push("mid_rst_pred", 0, 0.5);
    rst      = 1'b0;
    training = 1'b0;
    edge1();

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
